instr_fetch_unit: RTL and testbench

//  Instruction fetch stage of the RISC-V core. Holds the PC, issues word reads
//  to instruction memory, and buffers returned words in a small in-order queue.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core-wide widths, constants and fetch-stage types.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   // I-type immediate slice handed to the sign-extend unit
   localparam int unsigned IMM_I_MSB = 31;
   localparam int unsigned IMM_I_LSB = 20;
   localparam int unsigned IMM_I_W   = IMM_I_MSB - IMM_I_LSB + 1;

   typedef enum logic [0:0] {
      RUN,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface instr_fetch_unit_if;

   logic                          imem_req_valid;
   logic                          imem_req_ready;
   logic [riscv_pkg::XLEN-1:0]    imem_req_addr;
   logic                          imem_rsp_valid;
   logic [riscv_pkg::ILEN-1:0]    imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush; flush wins over a same-cycle push or pop.
module fetch_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [Width-1:0]         push_data,
   input  logic                     pop,
   output logic [Width-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] FullCnt = Depth[AW:0];

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;

   assign full     = (count_q == FullCnt);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: reads are qualified by the count.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-V instruction fetch: PC, credit-based imem requests, in-order queue, redirect drain.
// Optional `FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_unit_if.master   imem,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   input  logic                 dec_ready,
   output logic                 instr_valid,
   output logic [ILEN-1:0]      instr,
   output logic [XLEN-1:0]      instr_pc,
   output logic [IMM_I_W-1:0]   imm_field
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_stall
`endif
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] target_q, target_d;
   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [CntW-1:0] discard_q, discard_d;
   logic            hold_q, hold_d;

   logic            req_valid, accept, pop, credit;
   logic [31:0]     in_use;
   logic [CntW-1:0] acc_cnt, rsp_cnt, drain_left;
   logic [XLEN-1:0] redirect_target;

   logic                     iq_push, iq_full, iq_empty;
   logic [CntW-1:0]          iq_count;
   logic [FETCH_ENTRY_W-1:0] iq_wr_data, iq_rd_data;
   fetch_entry_t             iq_head, iq_new;

   logic            tag_push, tag_pop, tag_full, tag_empty;
   logic [CntW-1:0] tag_count;
   logic [XLEN-1:0] tag_pc;

   // ---------------------------------------------------------------------------------------------
   // Request side
   // ---------------------------------------------------------------------------------------------
   // A slot freed by this cycle's pop counts, keeping the stream gapless at depth 2; a granted
   // credit is never revoked, so hold_q keeps valid stable until the request is accepted.
   assign pop       = instr_valid && dec_ready;
   assign in_use    = 32'(outstanding_q) + 32'(iq_count);
   assign credit    = in_use < (FIFO_DEPTH + 32'(pop));
   assign req_valid = rst_n && (state_q == RUN) && (credit || hold_q);
   assign accept    = req_valid && imem.imem_req_ready;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;

   // ---------------------------------------------------------------------------------------------
   // Tag (PC) queue and instruction queue
   // ---------------------------------------------------------------------------------------------
   assign tag_push = accept;
   assign tag_pop  = imem.imem_rsp_valid && (state_q == RUN);
   assign iq_push  = imem.imem_rsp_valid && (state_q == RUN) && !redirect_valid;

   assign iq_new.pc    = tag_pc;
   assign iq_new.instr = imem.imem_rsp_data;
   assign iq_wr_data   = iq_new;
   assign iq_head      = fetch_entry_t'(iq_rd_data);

   fetch_fifo #(
      .Width (XLEN),
      .Depth (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (tag_push),
      .push_data (pc_q),
      .pop       (tag_pop),
      .pop_data  (tag_pc),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   fetch_fifo #(
      .Width (FETCH_ENTRY_W),
      .Depth (FIFO_DEPTH)
   ) u_instr_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (iq_push),
      .push_data (iq_wr_data),
      .pop       (pop),
      .pop_data  (iq_rd_data),
      .full      (iq_full),
      .empty     (iq_empty),
      .count     (iq_count)
   );

   assign instr_valid = !iq_empty;
   assign instr       = instr_valid ? iq_head.instr : '0;
   assign instr_pc    = instr_valid ? iq_head.pc : '0;
   assign imm_field   = instr[IMM_I_MSB:IMM_I_LSB];

   // ---------------------------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      target_d        = target_q;
      discard_d       = discard_q;
      hold_d          = req_valid && !imem.imem_req_ready && !redirect_valid;
      acc_cnt         = CntW'(accept);
      rsp_cnt         = CntW'(imem.imem_rsp_valid);
      outstanding_d   = outstanding_q + acc_cnt - rsp_cnt;
      redirect_target = word_align(redirect_pc);
      drain_left      = '0;

      if (accept) begin
         pc_d = pc_q + 32'd4;
      end

      case (state_q)
         RUN: begin
            if (redirect_valid) begin
               // Same-cycle accept is counted, same-cycle response is already dropped.
               drain_left = outstanding_d;
               if (drain_left == '0) begin
                  pc_d = redirect_target;
               end else begin
                  state_d   = DRAIN;
                  discard_d = drain_left;
                  target_d  = redirect_target;
               end
            end
         end
         DRAIN: begin
            drain_left = discard_q - rsp_cnt;
            discard_d  = drain_left;
            if (redirect_valid) begin
               target_d = redirect_target;
            end
            if (drain_left == '0) begin
               state_d = RUN;
               pc_d    = target_d;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         target_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         hold_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         target_q      <= target_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         hold_q        <= hold_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
         if ((state_q == RUN) && !instr_valid) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

   // ---------------------------------------------------------------------------------------------
   // Invariants of the credit scheme
   // ---------------------------------------------------------------------------------------------
   a_iq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(iq_push && iq_full));

   a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(tag_push && tag_full && !redirect_valid));

   a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(tag_pop && tag_empty));

   a_tags_track_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RUN) |-> (tag_count == outstanding_q));

   a_rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      imem.imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model (optional stall).
module tb_instr_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [11:0] imm_field;
   logic        mem_stall;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;
   int acc_base;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (bus.master),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .imm_field      (imm_field)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // In-order memory: one-cycle latency unless mem_stall holds responses back.
   logic [31:0] mq[$];
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         bus.imem_rsp_valid <= 1'b0;
         bus.imem_rsp_data  <= '0;
      end else begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back(bus.imem_req_addr);
            n_acc++;
         end
         if (!mem_stall && mq.size() > 0) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rsp_data  <= mq.pop_front() ^ KEY;
         end else begin
            bus.imem_rsp_valid <= 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.imem_req_valid && n < 50) begin
         tick();
         n++;
      end
      if (!bus.imem_req_valid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_instr(input string tag);
      int n = 0;
      while (!instr_valid && n < 50) begin
         tick();
         n++;
      end
      if (!instr_valid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst_n              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      dec_ready          = 1'b1;
      mem_stall          = 1'b0;
      bus.imem_req_ready = 1'b1;
      tick();
      tick();

      // 1. reset values, then streaming at one instruction per cycle
      check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_instr", instr, 32'd0);
      check_eq("rst_instr_pc", instr_pc, 32'd0);
      rst_n = 1'b1;
      #1;
      check_eq("t1_first_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("t1_first_addr", bus.imem_req_addr, 32'd0);
      tick();
      check_eq("t1_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
      check_eq("t1_latency", 32'(instr_valid), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("t1_valid", 32'(instr_valid), 32'd1);
         check_eq("t1_pc", instr_pc, 32'(4 * i));
         check_eq("t1_instr", instr, 32'(4 * i) ^ KEY);
         tick();
      end
      check_eq("t1_imm", 32'(imm_field), 32'h0000_0A5A);

      // 2. decode stalled: credit stops at FIFO_DEPTH requests, head stable
      dec_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n    = 1'b1;
      acc_base = n_acc;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 3) check_eq("t2_head_early", instr_pc, 32'd0);
      end
      check_eq("t2_accepts", 32'(n_acc - acc_base), 32'd2);
      check_eq("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_eq("t2_head_valid", 32'(instr_valid), 32'd1);
      check_eq("t2_head_pc", instr_pc, 32'd0);
      check_eq("t2_head_instr", instr, KEY);

      // 3. redirect with two outstanding requests drains stale responses
      dec_ready = 1'b0;
      mem_stall = 1'b1;
      do_reset();
      acc_base = n_acc;
      repeat (4) tick();
      check_eq("t3_accepts", 32'(n_acc - acc_base), 32'd2);
      redirect(32'h0000_0100);
      mem_stall = 1'b0;
      #1;
      check_eq("t3_drain_no_req", 32'(bus.imem_req_valid), 32'd0);
      check_eq("t3_flushed", 32'(instr_valid), 32'd0);
      dec_ready = 1'b1;
      wait_req("t3_req");
      check_eq("t3_addr", bus.imem_req_addr, 32'h0000_0100);
      wait_instr("t3_instr");
      check_eq("t3_pc", instr_pc, 32'h0000_0100);
      check_eq("t3_instr", instr, 32'h0000_0100 ^ KEY);

      // 4. memory not ready: request held, redirect retargets it
      bus.imem_req_ready = 1'b0;
      dec_ready          = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         check_eq("t4_hold_valid", 32'(bus.imem_req_valid), 32'd1);
         check_eq("t4_hold_addr", bus.imem_req_addr, 32'd0);
         tick();
      end
      redirect(32'h0000_0040);
      check_eq("t4_retarget_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("t4_retarget_addr", bus.imem_req_addr, 32'h0000_0040);
      bus.imem_req_ready = 1'b1;
      wait_instr("t4_instr");
      check_eq("t4_pc", instr_pc, 32'h0000_0040);

      // 5. low PC bits ignored; last of back-to-back redirects in DRAIN wins
      bus.imem_req_ready = 1'b0;
      dec_ready          = 1'b0;
      do_reset();
      redirect(32'h0000_0203);
      check_eq("t5_aligned", bus.imem_req_addr, 32'h0000_0200);
      bus.imem_req_ready = 1'b1;
      mem_stall          = 1'b1;
      tick();
      tick();
      check_eq("t5_credit_out", 32'(bus.imem_req_valid), 32'd0);
      redirect(32'h0000_0300);
      redirect(32'h0000_0400);
      redirect(32'h0000_0500);
      mem_stall = 1'b0;
      dec_ready = 1'b1;
      wait_req("t5_req");
      check_eq("t5_addr", bus.imem_req_addr, 32'h0000_0500);
      wait_instr("t5_instr");
      check_eq("t5_pc", instr_pc, 32'h0000_0500);
      check_eq("t5_instr", instr, 32'h0000_0500 ^ KEY);

      // 6. reset with a full queue
      dec_ready = 1'b0;
      do_reset();
      repeat (6) tick();
      check_eq("t6_full_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_PERF_EN
      check_eq("t6_perf_fetched_pre", perf_fetched, 32'd0);
      check_eq("t6_perf_stall_pre", perf_stall, 32'd2);
`endif
      rst_n = 1'b0;
      tick();
      check_eq("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
      check_eq("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
`ifdef FETCH_PERF_EN
      check_eq("t6_perf_fetched", perf_fetched, 32'd0);
      check_eq("t6_perf_stall", perf_stall, 32'd0);
`endif
      tick();
      rst_n     = 1'b1;
      dec_ready = 1'b1;
      #1;
      check_eq("t6_restart_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("t6_restart_addr", bus.imem_req_addr, 32'd0);
      wait_instr("t6_instr");
      check_eq("t6_pc", instr_pc, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
